// File: rtl/vc_sched_pkg.sv
// Shared types and constants for the VC plane scheduler.
// Holds the scheduler state encoding and the mode_i encodings.
package vc_sched_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_PARK = 2'd2
    } state_e;

    localparam logic MODE_TDM = 1'b0;
    localparam logic MODE_WC  = 1'b1;

endpackage

// File: rtl/vc_rr_next.sv
// Rotating find-first: returns the first set bit of elig_i at or after cur_i+1,
// wrapping modulo VC, so cur_i itself is found only as the last candidate.
module vc_rr_next
    import vc_sched_pkg::*;
#(
    parameter int unsigned VC    = 4,
    parameter int unsigned SEL_W = (VC > 1) ? $clog2(VC) : 1
) (
    input  logic [VC-1:0]    elig_i,
    input  logic [SEL_W-1:0] cur_i,
    output logic [SEL_W-1:0] next_o,
    output logic             found_o
);

    always_comb begin
        int unsigned idx;
        next_o  = cur_i;
        found_o = 1'b0;
        idx     = 0;
        for (int unsigned off = 1; off <= VC; off++) begin
            idx = 32'(cur_i) + off;
            if (idx >= VC) begin
                idx = idx - VC;
            end
            if (!found_o && elig_i[SEL_W'(idx)]) begin
                found_o = 1'b1;
                next_o  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vc_plane_scheduler.sv
// Weighted slot scheduler across VC planes: strict TDM or work-conserving,
// with hold, parking when nothing is eligible, and registered outputs only.
module vc_plane_scheduler
    import vc_sched_pkg::*;
#(
    parameter int unsigned VC     = 4,
    parameter int unsigned SLOT_W = 4,
    parameter int unsigned INIT   = 0,
    localparam int unsigned SEL_W = (VC > 1) ? $clog2(VC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [VC*SLOT_W-1:0] weight_i,
    input  logic [VC-1:0]        vc_req_i,
    input  logic                 mode_i,
    input  logic                 hold_i,
    output logic [SEL_W-1:0]     sel_o,
    output logic [VC-1:0]        sel_onehot_o,
    output logic                 sel_valid_o,
    output logic                 slot_start_o
);

    localparam int unsigned      INIT_PREV     = (INIT + VC - 1) % VC;
    localparam logic [SEL_W-1:0] INIT_SEL      = SEL_W'(INIT);
    localparam logic [SEL_W-1:0] INIT_PREV_SEL = SEL_W'(INIT_PREV);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SLOT_W-1:0]  cnt_q, cnt_d;
    logic               slot_start_q, slot_start_d;

    logic [SLOT_W-1:0]  weight_a [VC];
    logic [VC-1:0]      elig;
    logic [SEL_W-1:0]   init_next, run_next;
    logic               init_found, run_found;
    logic               advance;

    // Per-plane weight slice and eligibility under the current mode
    for (genvar k = 0; k < VC; k++) begin : g_plane
        assign weight_a[k] = weight_i[k*SLOT_W +: SLOT_W];
        assign elig[k]     = (weight_a[k] != '0) && ((mode_i == MODE_TDM) || vc_req_i[k]);
    end

    // Entry search starts at INIT itself, so rotate from the plane below it
    vc_rr_next #(.VC(VC), .SEL_W(SEL_W)) u_rr_init (
        .elig_i  (elig),
        .cur_i   (INIT_PREV_SEL),
        .next_o  (init_next),
        .found_o (init_found)
    );

    vc_rr_next #(.VC(VC), .SEL_W(SEL_W)) u_rr_run (
        .elig_i  (elig),
        .cur_i   (sel_q),
        .next_o  (run_next),
        .found_o (run_found)
    );

    assign advance = (cnt_q == '0) || ((mode_i == MODE_WC) && !vc_req_i[sel_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!hold_i) begin
            unique case (state_q)
                S_INIT:  state_d = init_found ? S_RUN : S_PARK;
                S_RUN:   if (advance) state_d = run_found ? S_RUN : S_PARK;
                S_PARK:  if (run_found) state_d = S_RUN;
                default: state_d = S_INIT;
            endcase
        end
    end

    always_comb begin
        sel_valid_o  = (state_q == S_RUN);
        sel_onehot_o = '0;
        if (state_q == S_RUN) begin
            sel_onehot_o[sel_q] = 1'b1;
        end
    end

    assign sel_o        = sel_q;
    assign slot_start_o = slot_start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= INIT_SEL;
            cnt_q        <= '0;
            slot_start_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            slot_start_q <= slot_start_d;
        end
    end

    // Slot load / countdown; weight is sampled only at the load cycle
    always_comb begin
        logic              load;
        logic [SEL_W-1:0]  load_idx;
        logic [SLOT_W-1:0] load_w;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        slot_start_d = 1'b0;
        load         = 1'b0;
        load_idx     = run_next;
        if (!hold_i) begin
            unique case (state_q)
                S_INIT: begin
                    load     = init_found;
                    load_idx = init_next;
                end
                S_RUN: begin
                    if (advance) begin
                        load = run_found;
                    end else begin
                        cnt_d = cnt_q - SLOT_W'(1);
                    end
                end
                S_PARK:  load = run_found;
                default: load = 1'b0;
            endcase
        end
        load_w = weight_a[load_idx];
        if (load) begin
            sel_d        = load_idx;
            cnt_d        = (load_w != '0) ? load_w - SLOT_W'(1) : '0;
            slot_start_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Scoreboard bench for vc_plane_scheduler: a slot-level reference model pushes
// expected outputs each cycle; an independent monitor pops and compares.
module tb_vc_plane_scheduler;

    localparam int unsigned VC     = 4;
    localparam int unsigned SLOT_W = 4;
    localparam int unsigned INIT   = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] weight;
    logic [3:0]  vc_req;
    logic        mode;
    logic        hold;
    logic [1:0]  sel_o;
    logic [3:0]  sel_onehot_o;
    logic        sel_valid_o;
    logic        slot_start_o;

    vc_plane_scheduler #(.VC(VC), .SLOT_W(SLOT_W), .INIT(INIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .weight_i     (weight),
        .vc_req_i     (vc_req),
        .mode_i       (mode),
        .hold_i       (hold),
        .sel_o        (sel_o),
        .sel_onehot_o (sel_onehot_o),
        .sel_valid_o  (sel_valid_o),
        .slot_start_o (slot_start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] s;
        logic [3:0] oh;
        logic       st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0=init, 1=running a slot, 2=parked
    int   m_phase, m_sel, m_left;
    bit   m_start;
    logic [15:0] p_w;
    logic [3:0]  p_req;
    logic        p_mode, p_hold, p_rst;

    function automatic int find_from(int start, logic [15:0] w, logic [3:0] req, logic md);
        for (int off = 0; off < VC; off++) begin
            int k;
            k = (start + off) % VC;
            if (w[k*4 +: 4] != 4'd0 && (!md || req[k])) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_sel   = INIT;
        m_left  = 0;
        m_start = 1'b0;
    endtask

    task automatic load_slot(int k);
        m_sel   = k;
        m_left  = int'(p_w[k*4 +: 4]);
        m_start = 1'b1;
        m_phase = 1;
    endtask

    task automatic model_edge();
        int pick;
        if (!p_rst) begin
            model_reset();
            return;
        end
        m_start = 1'b0;
        if (p_hold) return;
        case (m_phase)
            0: begin
                pick = find_from(INIT, p_w, p_req, p_mode);
                if (pick >= 0) load_slot(pick); else m_phase = 2;
            end
            1: begin
                if (m_left <= 1 || (p_mode && !p_req[m_sel])) begin
                    pick = find_from((m_sel + 1) % VC, p_w, p_req, p_mode);
                    if (pick >= 0) load_slot(pick); else m_phase = 2;
                end else begin
                    m_left = m_left - 1;
                end
            end
            default: begin
                pick = find_from((m_sel + 1) % VC, p_w, p_req, p_mode);
                if (pick >= 0) load_slot(pick);
            end
        endcase
    endtask

    task automatic step(input logic [15:0] w, input logic [3:0] req,
                        input logic md, input logic hd, input logic rn);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        rst_n  = rn;
        weight = w;
        vc_req = req;
        mode   = md;
        hold   = hd;
        if (!rn) model_reset();
        e.v  = (m_phase == 1);
        e.s  = 2'(m_sel);
        e.oh = e.v ? 4'(1 << m_sel) : 4'b0000;
        e.st = m_start;
        exp_q.push_back(e);
        p_w = w; p_req = req; p_mode = md; p_hold = hd; p_rst = rn;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sel_valid",  int'(sel_valid_o),  int'(e.v));
            chk("sel",        int'(sel_o),        int'(e.s));
            chk("onehot",     int'(sel_onehot_o), int'(e.oh));
            chk("slot_start", int'(slot_start_o), int'(e.st));
        end
    end

    task automatic wait_bound(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=timeout expected=condition reached", name);
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [3:0]  rq;
        logic        md;
        bit          ok;
        rst_n = 1'b0; weight = '0; vc_req = '0; mode = 1'b0; hold = 1'b0;
        p_w = '0; p_req = '0; p_mode = 1'b0; p_hold = 1'b0; p_rst = 1'b0;
        model_reset();

        repeat (3) step(16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);

        // TDM {3,1,1,1}
        repeat (14) step(16'h1113, 4'hF, 1'b0, 1'b0, 1'b1);
        // TDM {2,0,3,0}: planes 1 and 3 never chosen
        repeat (12) step(16'h0302, 4'hF, 1'b0, 1'b0, 1'b1);

        // WC {4,4,4,4}, req 0101, drop req[0] in the 2nd cycle of plane 0
        step(16'h4444, 4'h5, 1'b1, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step(16'h4444, 4'h5, 1'b1, 1'b0, 1'b1);
            ok = (m_phase == 1 && m_sel == 0 && m_start);
        end
        wait_bound("wc_plane0_slot", ok);
        repeat (6) step(16'h4444, 4'h4, 1'b1, 1'b0, 1'b1);

        // WC all requests low -> park, then req[3]
        repeat (4) step(16'h4444, 4'h0, 1'b1, 1'b0, 1'b1);
        repeat (6) step(16'h4444, 4'h8, 1'b1, 1'b0, 1'b1);

        // Hold for 5 cycles mid-slot with cnt=2
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step(16'h4444, 4'hF, 1'b0, 1'b0, 1'b1);
            ok = (m_phase == 1 && m_left == 3);
        end
        wait_bound("hold_setup", ok);
        repeat (5) step(16'h4444, 4'hF, 1'b0, 1'b1, 1'b1);
        repeat (6) step(16'h4444, 4'hF, 1'b0, 1'b0, 1'b1);

        // Reset pulse mid-slot
        step(16'h4444, 4'hF, 1'b0, 1'b0, 1'b1);
        step(16'h4444, 4'hF, 1'b0, 1'b0, 1'b0);
        repeat (5) step(16'h4444, 4'hF, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        w = 16'h2131; rq = 4'hF; md = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 4; k++) w[k*4 +: 4] = 4'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 2) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 29) == 0) md = ~md;
            step(w, rq, md, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) != 0));
        end

        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (exp_q.size() == 0);
        end
        wait_bound("scoreboard_drain", ok);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
